// File: rtl/pwm_capture.sv
// PWM measurement: high time, period and 64-step duty of an asynchronous PWM input.
// Optional deglitch filter on the synchronised input is enabled by defining DEGLITCH_EN.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 65535,
  parameter int FILT_LEN = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [5:0]       duty,
  output logic             valid,
  output logic             is_static,
  output logic             overrun
);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] P_MAX = '1;
  localparam logic [CNT_W-1:0] P_TO  = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == P_MAX) ? v : v + 1'b1;
  endfunction

  // One restoring step: returns {quotient bit, new remainder}.
  function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                               input logic [CNT_W-1:0] d);
    logic [CNT_W:0] sh;
    sh = {rem, 1'b0};
    if (sh >= {1'b0, d}) return {1'b1, CNT_W'(sh - {1'b0, d})};
    return {1'b0, sh[CNT_W-1:0]};
  endfunction

  logic r_sync1, r_sync2, r_s_d;
  logic w_s, w_rise, w_fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEGLITCH_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);
  logic            r_filt;
  logic [FC_W-1:0] r_fcnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FC_W'(FILT_LEN - 1)) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end
  assign w_s = r_filt;
`else
  logic w_unused_filt;
  assign w_unused_filt = (FILT_LEN != 0);
  assign w_s = r_sync2;
`endif

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  state_t           r_state;
  logic [CNT_W-1:0] r_p, r_h_tmp, r_div_h, r_div_p, r_rem;
  logic [5:0]       r_q;
  logic [2:0]       r_div_cnt;
  logic             r_busy, r_to_pend, r_to_seen;
  logic             w_to, w_start, w_ovr, w_div_done;
  logic [CNT_W:0]   w_step;
  logic [5:0]       w_q_next;

  // r_to_seen keeps a counter parked at TIMEOUT (possible when TIMEOUT is all-ones) from refiring.
  assign w_to       = (r_p == P_TO) && !w_rise && !r_to_seen;
  assign w_start    = (r_state == MEAS_LOW) && w_rise && !r_busy;
  assign w_ovr      = (r_state == MEAS_LOW) && w_rise && r_busy;
  assign w_step     = div_step(r_rem, r_div_p);
  assign w_q_next   = {r_q[4:0], w_step[CNT_W]};
  assign w_div_done = r_busy && (r_div_cnt == 3'd5);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= WAIT_RISE;
      r_p       <= '0;
      r_h_tmp   <= '0;
      r_s_d     <= 1'b0;
      r_to_seen <= 1'b0;
    end else begin
      r_s_d <= w_s;
      r_p   <= w_rise ? CNT_W'(1) : sat_inc(r_p);
      if (w_rise)    r_to_seen <= 1'b0;
      else if (w_to) r_to_seen <= 1'b1;
      if (w_to) begin
        r_state <= WAIT_RISE;
      end else begin
        case (r_state)
          WAIT_RISE: if (w_rise) r_state <= MEAS_HIGH;
          MEAS_HIGH: if (w_fall) begin
            r_h_tmp <= r_p;
            r_state <= MEAS_LOW;
          end
          MEAS_LOW:  if (w_rise) r_state <= MEAS_HIGH;
          default:   r_state <= WAIT_RISE;
        endcase
      end
    end
  end

  // An overrun also abandons an unfinished division, so periods under 8 cycles never report.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= 1'b0;
      r_div_cnt <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_div_h   <= '0;
      r_div_p   <= '0;
    end else if (w_start) begin
      r_busy    <= 1'b1;
      r_div_cnt <= '0;
      r_rem     <= r_h_tmp;
      r_q       <= '0;
      r_div_h   <= r_h_tmp;
      r_div_p   <= r_p;
    end else if (w_ovr) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (r_div_cnt == 3'd6) begin
        r_busy <= 1'b0;
      end else begin
        r_rem     <= w_step[CNT_W-1:0];
        r_q       <= w_q_next;
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      high_time <= '0;
      period    <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      is_static <= 1'b0;
      overrun   <= 1'b0;
      r_to_pend <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= w_ovr;
      if (w_div_done) begin
        high_time <= r_div_h;
        period    <= r_div_p;
        duty      <= w_q_next;
        is_static <= 1'b0;
        valid     <= 1'b1;
        r_to_pend <= w_to;
      end else if (w_to || r_to_pend) begin
        is_static <= 1'b1;
        duty      <= w_s ? 6'd63 : 6'd0;
        valid     <= 1'b1;
        r_to_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture; expectations are queued as each PWM edge is driven.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
  localparam int FILT    = 3;
`ifdef DEGLITCH_EN
  localparam int LAT = 9 + FILT;
`else
  localparam int LAT = 9;
`endif
  localparam int TO_LAT = TIMEOUT + LAT - 6;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_time, period;
  logic [5:0]       duty;
  logic             valid, is_static, overrun;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT)) dut (
    .clock(clock), .reset_n(reset_n), .pwm_in(pwm_in),
    .high_time(high_time), .period(period), .duty(duty),
    .valid(valid), .is_static(is_static), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct { int h; int p; int duty; int stat; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, ov_cnt = 0, exp_ov = 0;
  int have_prev = 0, busy = 0, start_cyc = 0, last_rise = 0;
  int last_h = 0, last_l = 0, rep_h = 0, rep_p = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin rep_h = 0; rep_p = 0; end
      if (overrun) ov_cnt++;
      if (valid) begin
        if (sbq.size() == 0) check_val("spurious_valid", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check_val("valid_cycle", cyc, mon_e.cyc);
          check_val("is_static", int'(is_static), mon_e.stat);
          check_val("duty", int'(duty), mon_e.duty);
          if (mon_e.stat != 0) begin
            check_val("static_high_time_hold", int'(high_time), rep_h);
            check_val("static_period_hold", int'(period), rep_p);
          end else begin
            check_val("high_time", int'(high_time), mon_e.h);
            check_val("period", int'(period), mon_e.p);
            rep_h = mon_e.h;
            rep_p = mon_e.p;
          end
        end
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clock);
  endtask

  // Model of one detected rise: result of the finished period, or an overrun drop.
  task automatic do_rise();
    int   d;
    exp_t e;
    d = cyc - start_cyc;
    if (have_prev != 0) begin
      if (busy != 0 && d <= 7) begin
        exp_ov++;
        if (d <= 5) sbq.delete(sbq.size() - 1);
        busy = 0;
      end else begin
        e.h = last_h; e.p = last_h + last_l;
        e.duty = (last_h * 64) / (last_h + last_l);
        e.stat = 0; e.cyc = cyc + LAT;
        sbq.push_back(e);
        busy = 1; start_cyc = cyc;
      end
    end
    last_rise = cyc;
  endtask

  task automatic pulse(input int h, input int l, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      do_rise();
      repeat (h) @(negedge clock);
      pwm_in = 1'b0;
      repeat (l) @(negedge clock);
      last_h = h; last_l = l; have_prev = 1;
    end
  endtask

  task automatic static_hold(input logic lvl, input int n);
    exp_t e;
    e.h = 0; e.p = 0; e.duty = lvl ? 63 : 0; e.stat = 1;
    e.cyc = last_rise + TO_LAT;
    sbq.push_back(e);
    have_prev = 0;
    hold(lvl, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_high_time"}, int'(high_time), 0);
    check_val({tag, "_period"}, int'(period), 0);
    check_val({tag, "_duty"}, int'(duty), 0);
    check_val({tag, "_valid"}, int'(valid), 0);
    check_val({tag, "_is_static"}, int'(is_static), 0);
    check_val({tag, "_overrun"}, int'(overrun), 0);
  endtask

`ifdef DEGLITCH_EN
  task automatic glitch_pulse();
    pwm_in = 1'b1;
    do_rise();
    hold(1'b1, 4); hold(1'b0, 1); hold(1'b1, 5); hold(1'b0, 22);
    last_h = 10; last_l = 22; have_prev = 1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    hold(1'b0, 2);

    pulse(10, 22, 4);
    pulse(31, 33, 2);
`ifndef DEGLITCH_EN
    pulse(1, 63, 2);
    pulse(63, 1, 2);
    pulse(2, 3, 6);
    check_val("overruns_after_short_burst", ov_cnt, exp_ov);
`endif
    static_hold(1'b0, 150);

    pulse(10, 22, 2);
    pwm_in = 1'b1;
    do_rise();
    static_hold(1'b1, 150);
    hold(1'b0, 20);
    pulse(8, 8, 3);

    pwm_in = 1'b1;
    do_rise();
    hold(1'b1, 10);
    hold(1'b0, 5);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_low");
    check_val("queue_empty_at_reset", sbq.size(), 0);
    have_prev = 0; busy = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    hold(1'b0, 3);
    pulse(10, 22, 3);

`ifdef DEGLITCH_EN
    glitch_pulse();
    glitch_pulse();
`else
    pulse(4, 1, 1);
    pulse(5, 22, 1);
`endif
    pulse(10, 22, 2);
    hold(1'b0, 40);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clock);
    check_val("scoreboard_drained", sbq.size(), 0);
    check_val("overrun_total", ov_cnt, exp_ov);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
